// File: rtl/riscv_alu_shared_responder_if.sv
// Offload handshake bundle between the core ALU (master) and the shared-DSP responder (slave).
// Request side is req/gnt; response side is rvalid/rready with result, error flag and echoed tag.
interface riscv_alu_shared_responder_if #(
  parameter int TAG_WIDTH    = 2,
  parameter int ALU_OP_WIDTH = 7
);
  logic                    req_i;
  logic                    gnt_o;
  logic [ALU_OP_WIDTH-1:0] operator_i;
  logic [31:0]             operand_a_i;
  logic [31:0]             operand_b_i;
  logic [TAG_WIDTH-1:0]    tag_i;
  logic                    rvalid_o;
  logic                    rready_i;
  logic [31:0]             result_o;
  logic                    err_o;
  logic [TAG_WIDTH-1:0]    tag_o;

  modport slave (
    input  req_i, operator_i, operand_a_i, operand_b_i, tag_i, rready_i,
    output gnt_o, rvalid_o, result_o, err_o, tag_o
  );

  modport master (
    output req_i, operator_i, operand_a_i, operand_b_i, tag_i, rready_i,
    input  gnt_o, rvalid_o, result_o, err_o, tag_o
  );
endinterface

// File: rtl/riscv_alu_shared_responder.sv
// Responder for ALU ops the minimal core lacks: MIN/MAX/ABS/CLIP in one cycle, bit counting
// iteratively over fixed-size chunks of operand A. One request in flight at a time.
module riscv_alu_shared_responder #(
  parameter int TAG_WIDTH          = 2,
  parameter int CNT_BITS_PER_CYCLE = 8
) (
  input logic                          clk,
  input logic                          rst_n,
  riscv_alu_shared_responder_if.slave  bus
);
  localparam int N   = CNT_BITS_PER_CYCLE;
  localparam int NCH = 32 / N;

  localparam logic [6:0] ALU_MIN   = 7'b0010000;
  localparam logic [6:0] ALU_MINU  = 7'b0010001;
  localparam logic [6:0] ALU_MAX   = 7'b0010010;
  localparam logic [6:0] ALU_MAXU  = 7'b0010011;
  localparam logic [6:0] ALU_ABS   = 7'b0010100;
  localparam logic [6:0] ALU_CLIP  = 7'b0010110;
  localparam logic [6:0] ALU_CLIPU = 7'b0010111;
  localparam logic [6:0] ALU_CNT   = 7'b0110100;
  localparam logic [6:0] ALU_FF1   = 7'b0110110;
  localparam logic [6:0] ALU_FL1   = 7'b0110111;

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_e;

  state_e               state_q, state_d;
  logic [6:0]           op_q, op_d;
  logic [31:0]          a_q, a_d;
  logic [TAG_WIDTH-1:0] tag_q, tag_d, rtag_q, rtag_d;
  logic [5:0]           cnt_q, cnt_d, acc_q, acc_d;
  logic [31:0]          result_q, result_d;
  logic                 err_q, err_d;

  logic                 accept;
  logic                 is_iter;
  logic                 single_err;
  logic [31:0]          single_res;
  logic [N-1:0]         chunk;
  logic [5:0]           pop, lo, hi, base, acc_step;

  assign bus.gnt_o    = (state_q == IDLE) & rst_n;
  assign accept       = bus.req_i & bus.gnt_o;
  assign bus.rvalid_o = (state_q == RESP);
  assign bus.result_o = result_q;
  assign bus.err_o    = err_q;
  assign bus.tag_o    = rtag_q;

  always_comb begin
    single_res = '0;
    single_err = 1'b0;
    is_iter    = 1'b0;
    case (bus.operator_i)
      ALU_MIN:  single_res = ($signed(bus.operand_a_i) < $signed(bus.operand_b_i)) ? bus.operand_a_i : bus.operand_b_i;
      ALU_MAX:  single_res = ($signed(bus.operand_a_i) > $signed(bus.operand_b_i)) ? bus.operand_a_i : bus.operand_b_i;
      ALU_MINU: single_res = (bus.operand_a_i < bus.operand_b_i) ? bus.operand_a_i : bus.operand_b_i;
      ALU_MAXU: single_res = (bus.operand_a_i > bus.operand_b_i) ? bus.operand_a_i : bus.operand_b_i;
      ALU_ABS:  single_res = bus.operand_a_i[31] ? (~bus.operand_a_i + 32'd1) : bus.operand_a_i;
      ALU_CLIP: begin
        // Lower bound -(B+1) is simply ~B in two's complement.
        if (bus.operand_b_i[31])                                      single_res = bus.operand_b_i;
        else if ($signed(bus.operand_a_i) > $signed(bus.operand_b_i)) single_res = bus.operand_b_i;
        else if ($signed(bus.operand_a_i) < $signed(~bus.operand_b_i)) single_res = ~bus.operand_b_i;
        else                                                          single_res = bus.operand_a_i;
      end
      ALU_CLIPU: begin
        if (bus.operand_b_i[31] | bus.operand_a_i[31])  single_res = '0;
        else if (bus.operand_a_i > bus.operand_b_i)     single_res = bus.operand_b_i;
        else                                            single_res = bus.operand_a_i;
      end
      ALU_CNT, ALU_FF1, ALU_FL1: is_iter = 1'b1;
      default: single_err = 1'b1;
    endcase
  end

  always_comb begin
    chunk = N'(a_q >> (32'(cnt_q) * 32'(N)));
    base  = 6'(32'(cnt_q) * 32'(N));
    pop   = '0;
    lo    = '0;
    hi    = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (chunk[i]) lo = 6'(i);
    end
    for (int i = 0; i < N; i++) begin
      pop = pop + {5'd0, chunk[i]};
      if (chunk[i]) hi = 6'(i);
    end
    // FF1/FL1 start at 32, so 32 doubles as the "nothing found yet" marker.
    case (op_q)
      ALU_CNT: acc_step = acc_q + pop;
      ALU_FF1: acc_step = ((acc_q == 6'd32) && (|chunk)) ? (base + lo) : acc_q;
      ALU_FL1: acc_step = (|chunk) ? (base + hi) : acc_q;
      default: acc_step = acc_q;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    a_d      = a_q;
    tag_d    = tag_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    result_d = result_q;
    err_d    = err_q;
    rtag_d   = rtag_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          op_d  = bus.operator_i;
          a_d   = bus.operand_a_i;
          tag_d = bus.tag_i;
          if (is_iter) begin
            state_d = BUSY;
            cnt_d   = '0;
            acc_d   = (bus.operator_i == ALU_CNT) ? 6'd0 : 6'd32;
          end else begin
            state_d  = RESP;
            result_d = single_res;
            err_d    = single_err;
            rtag_d   = bus.tag_i;
          end
        end
      end
      BUSY: begin
        acc_d = acc_step;
        cnt_d = cnt_q + 6'd1;
        if (cnt_q == 6'(NCH - 1)) begin
          state_d  = RESP;
          result_d = {26'd0, acc_step};
          err_d    = 1'b0;
          rtag_d   = tag_q;
        end
      end
      RESP: begin
        if (bus.rready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      op_q     <= '0;
      a_q      <= '0;
      tag_q    <= '0;
      cnt_q    <= '0;
      acc_q    <= '0;
      result_q <= '0;
      err_q    <= 1'b0;
      rtag_q   <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      a_q      <= a_d;
      tag_q    <= tag_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      result_q <= result_d;
      err_q    <= err_d;
      rtag_q   <= rtag_d;
    end
  end

`ifndef SYNTHESIS
  a_resp_stable: assert property (@(posedge clk) disable iff (!rst_n)
    (bus.rvalid_o && !bus.rready_i) |=>
    (bus.rvalid_o && $stable(bus.result_o) && $stable(bus.err_o) && $stable(bus.tag_o)));
  a_gnt_rvalid_excl: assert property (@(posedge clk) disable iff (!rst_n)
    !(bus.gnt_o && bus.rvalid_o));
  if (!(N == 1 || N == 2 || N == 4 || N == 8 || N == 16 || N == 32)) begin : g_bad_cnt_bits
    $error("CNT_BITS_PER_CYCLE must be one of 1,2,4,8,16,32");
  end
`endif
endmodule
